dna_seq_loader: RTL
===================

Name: dna_seq_loader

Overview:
- Host-side initiator for the DNA pattern-search engine.
- Accepts a stream of 2-bit DNA bases over a valid/ready handshake and writes them into the engine's sequence memory.
- Then drives the engine's ready/dna_length inputs, waits for done, and returns found_it/error to the host as a held result with acknowledge.
- Sits between the host/UART front end and the search FSM.

Parameters:
ADDR_W, 16, width of mem_addr and dna_length
MAX_LEN, 1024, maximum bases per sequence (must be ≤ 2**ADDR_W)
MIN_LEN, 4, minimum sequence length the engine accepts (pattern length)
TIMEOUT, 65535, cycles allowed in WAIT before giving up

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
base_valid  in  1  host presents a base
base_in  in  2  base: A=00 C=01 G=10 T=11
base_last  in  1  qualifies the final base of a sequence
base_ready  out  1  loader can accept a base
mem_we  out  1  sequence-memory write enable
mem_addr  out  ADDR_W  write address
mem_data  out  2  write data
search_ready  out  1  to engine "ready": sequence loaded, start/continue search
dna_length  out  ADDR_W  to engine: number of valid bases
search_done  in  1  engine done
search_found  in  1  engine found_it, valid with search_done
search_error  in  1  engine error, valid with search_done
result_valid  out  1  result held for host
result_found  out  1  pattern found
result_code  out  3  0 OK, 1 SEARCH_ERR, 2 OVERFLOW, 3 TOO_SHORT, 4 TIMEOUT
result_ack  in  1  host consumes result

Behaviour:
- Reset (synchronous, wins over everything): state IDLE; every output 0 except base_ready=1. Base count, timer and overflow flag cleared. Memory contents are not cleared.
- Mid-operation reset: the next posedge returns to IDLE, search_ready drops, and any partial load is discarded.
- Transfer: a base is accepted on a posedge with base_valid && base_ready. base_ready=1 only in IDLE and LOAD.
- Write timing:
  - Registered write: a base accepted at edge k produces mem_we=1, mem_addr=count, mem_data=base at cycle k+1, for one cycle.
  - count increments per accepted base.
  - The first accept moves IDLE -> LOAD (or straight to length check if base_last).
- Overflow:
  - An accept when count==MAX_LEN is not written and sets the sticky ovf flag.
  - Loading continues, draining until base_last.
  - count saturates at MAX_LEN.
- On the base_last accept, len = count+1 (saturating). Next state:
  - ovf set -> REPORT with OVERFLOW.
  - len < MIN_LEN -> REPORT with TOO_SHORT.
  - Otherwise -> START.
  - No search is launched for OVERFLOW or TOO_SHORT.
- START (1 cycle, after the final mem_we has issued):
  - dna_length loaded with len and held stable until the next IDLE.
  - search_ready rises at the START->WAIT edge and stays high through WAIT; the engine treats it as a level.
- WAIT:
  - The timer increments each cycle.
  - search_done=1 -> capture search_found; code = search_error ? SEARCH_ERR : OK; go to REPORT.
  - timer==TIMEOUT-1 without done -> REPORT with TIMEOUT, found=0.
  - Done on the same cycle as timeout expiry: done wins.
- REPORT:
  - result_valid=1; result_found and result_code held stable; search_ready=0.
  - result_ack -> IDLE on the next edge; count, ovf and timer cleared; result outputs return to 0.
- Ignored inputs:
  - search_done outside WAIT.
  - result_ack outside REPORT.
  - base_valid outside IDLE/LOAD (base_ready=0).
- Widths: count and len are ADDR_W+1 bits internally to avoid wrap at MAX_LEN=2**ADDR_W. dna_length is the low ADDR_W bits.

Decomposition:
- Package dna_pkg holds:
  - base_t enum (A/C/G/T, 2 bits).
  - result_code_t enum (3 bits).
  - loader_state_t {IDLE, LOAD, START, WAIT, REPORT}.
- Single module otherwise. The timeout timer is a natural sub-module: dna_timeout_ctr (clear/enable/expired, parameter TIMEOUT).

Test Plan:
- Load ACGT,ACGA (8 bases, last on 8th); engine model returns done+found after 20 cycles -> 8 writes at addr 0..7 with data 00,01,10,11,00,01,10,00; dna_length=8; search_ready high for ~20 cycles; result_valid, found=1, code=0; ack -> IDLE, base_ready=1.
- Load 3 bases (MIN_LEN=4) -> 3 writes, search_ready never asserts, result code=3 (TOO_SHORT), found=0.
- MAX_LEN=8, send 10 bases -> exactly 8 writes (addr 0..7), base_ready stays 1 until last, code=2 (OVERFLOW), no search_ready.
- TIMEOUT=50, engine never responds -> search_ready high exactly 50 cycles, then result code=4, found=0. Repeat with done asserted on the expiry cycle -> code=0/1 per search_error.
- Engine returns done with error=1 -> code=1, found as returned. Hold result_ack low 10 cycles -> result stable, base_valid pulses not accepted.
- Assert reset during WAIT and during LOAD (after 5 bases) -> next edge: IDLE, search_ready=0, base_ready=1, result_valid=0. A new 4-base load writes from addr 0.

Source files
------------

// File: rtl/dna_pkg.sv
// Shared types for the DNA sequence loader: base encoding, result codes, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package dna_pkg;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } base_t;

    typedef enum logic [2:0] {
        RC_OK         = 3'd0,
        RC_SEARCH_ERR = 3'd1,
        RC_OVERFLOW   = 3'd2,
        RC_TOO_SHORT  = 3'd3,
        RC_TIMEOUT    = 3'd4
    } result_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_REPORT
    } loader_state_t;

endpackage

// File: rtl/dna_seq_loader_if.sv
// Bundle of host base stream, sequence-memory write port, engine control and host result.
// Latency: n/a (wiring only).
// Backpressure: base stream uses base_valid/base_ready; result is held until result_ack.
// Ports: master = host + engine side, slave = the loader.
interface dna_seq_loader_if #(
    parameter int ADDR_W = 16
);
    // host base stream
    logic              base_valid;
    logic [1:0]        base_in;
    logic              base_last;
    logic              base_ready;
    // sequence memory write port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_data;
    // search engine
    logic              search_ready;
    logic [ADDR_W-1:0] dna_length;
    logic              search_done;
    logic              search_found;
    logic              search_error;
    // host result
    logic              result_valid;
    logic              result_found;
    logic [2:0]        result_code;
    logic              result_ack;

    modport master (
        output base_valid, base_in, base_last,
        output search_done, search_found, search_error,
        output result_ack,
        input  base_ready, mem_we, mem_addr, mem_data,
        input  search_ready, dna_length,
        input  result_valid, result_found, result_code
    );

    modport slave (
        input  base_valid, base_in, base_last,
        input  search_done, search_found, search_error,
        input  result_ack,
        output base_ready, mem_we, mem_addr, mem_data,
        output search_ready, dna_length,
        output result_valid, result_found, result_code
    );
endinterface

// File: rtl/dna_timeout_ctr.sv
// Cycle counter that flags when TIMEOUT enabled cycles have elapsed since the last clear.
// Latency: expired is combinational from the count; asserted on the TIMEOUT-th enabled cycle.
// Backpressure: none.
// Ports: clock, reset (sync, active-high), clear, enable in; expired out.
module dna_timeout_ctr #(
    parameter int TIMEOUT = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign expired = enable && (cnt_q == LAST);
endmodule

// File: rtl/dna_seq_loader.sv
// Host-side initiator: streams bases into sequence memory, launches the search, holds the result.
// Latency: accepted base is written one cycle later; search_ready rises one cycle after the last write.
// Backpressure: base_ready only in IDLE/LOAD; result held in REPORT until result_ack.
// Ports: clock, reset (sync, active-high); bus (slave view of dna_seq_loader_if).
module dna_seq_loader
    import dna_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MAX_LEN = 1024,
    parameter int MIN_LEN = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clock,
    input  logic              reset,
    dna_seq_loader_if.slave   bus
);
    // one extra bit so a count of MAX_LEN == 2**ADDR_W does not wrap
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_LEN);

    loader_state_t     state_q, state_d;
    logic [CW-1:0]     count_q;
    logic              ovf_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [1:0]        mem_data_q;
    logic [ADDR_W-1:0] dna_length_q;
    logic              found_q, found_d;
    result_code_t      code_q, code_d;
    logic              capture;

    logic              accept;
    logic              room;
    logic [CW-1:0]     len_d;
    logic              timer_expired;

    assign accept = bus.base_valid && bus.base_ready;
    assign room   = count_q < MAX_C;
    // length including the base being accepted, saturated at MAX_LEN
    assign len_d  = room ? (count_q + CW'(1)) : MAX_C;

    dna_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        found_d = 1'b0;
        code_d  = RC_OK;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (bus.base_last) begin
                        // a last base arriving with no room is itself an overflow
                        if (ovf_q || !room) begin
                            state_d = ST_REPORT;
                            code_d  = RC_OVERFLOW;
                            capture = 1'b1;
                        end else if (len_d < MIN_C) begin
                            state_d = ST_REPORT;
                            code_d  = RC_TOO_SHORT;
                            capture = 1'b1;
                        end else begin
                            state_d = ST_START;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            // START covers the cycle in which the final write is on the memory port
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // done takes priority over a coincident timeout
                if (bus.search_done) begin
                    state_d = ST_REPORT;
                    found_d = bus.search_found;
                    code_d  = bus.search_error ? RC_SEARCH_ERR : RC_OK;
                    capture = 1'b1;
                end else if (timer_expired) begin
                    state_d = ST_REPORT;
                    code_d  = RC_TIMEOUT;
                    capture = 1'b1;
                end
            end
            ST_REPORT: begin
                if (bus.result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q      <= '0;
            ovf_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            dna_length_q <= '0;
            found_q      <= 1'b0;
            code_q       <= RC_OK;
        end else begin
            mem_we_q <= 1'b0;
            if (accept) begin
                if (room) begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= count_q[ADDR_W-1:0];
                    mem_data_q <= bus.base_in;
                    count_q    <= count_q + CW'(1);
                end else begin
                    ovf_q <= 1'b1;
                end
            end
            if (accept && bus.base_last && (state_d == ST_START)) begin
                dna_length_q <= len_d[ADDR_W-1:0];
            end
            if (capture) begin
                found_q <= found_d;
                code_q  <= code_d;
            end
            if ((state_q == ST_REPORT) && bus.result_ack) begin
                count_q      <= '0;
                ovf_q        <= 1'b0;
                dna_length_q <= '0;
                found_q      <= 1'b0;
                code_q       <= RC_OK;
            end
        end
    end

    assign bus.base_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.search_ready = (state_q == ST_WAIT);
    assign bus.dna_length   = dna_length_q;
    assign bus.result_valid = (state_q == ST_REPORT);
    assign bus.result_found = found_q;
    assign bus.result_code  = code_q;
endmodule
